pipelined_barrel_shifter: RTL and testbench
===========================================

// Module: pipelined_barrel_shifter
// PURPOSE
//  Operand-2 shifter for the data-processing path, WIDTH-generic, with a valid/ready handshake and 1-2 pipeline stages.
//  Covers immediate-rotate, immediate-shift and register-shift forms with full ARM edge semantics (#0 encodings, RRX, amounts >= WIDTH).
//  Produces the shifter carry-out consumed by flag logic (S-suffix logical ops).
//  Sits between register-read and the ALU; backpressure from ALU/hazard stall via out_ready.
// PARAMETERS
//  WIDTH        32   datapath width; power of two, 16..64
//  PIPE_STAGES  2    1: single register stage (decode+shift+mux in one cycle); 2: stage1 decodes amount/kind, stage2 shifts
//  SHW          $clog2(WIDTH)   localparam, immediate shift-amount width
// PORTS
//  clk          in   1      rising-edge clock
//  reset_n      in   1      synchronous active-low reset
//  in_valid     in   1      input operands valid
//  in_ready     out  1      shifter accepts this cycle
//  in_imm       in   1      1 = immediate form (instr bit 25)
//  in_regshift  in   1      1 = shift amount from Rs (instr bit 4); ignored when in_imm=1
//  in_sh        in   2      00 LSL, 01 LSR, 10 ASR, 11 ROR
//  in_shamt     in   SHW    immediate shift amount
//  in_rot       in   4      immediate rotate field; rotate amount = 2*in_rot mod WIDTH
//  in_imm8      in   8      immediate byte, zero-extended to WIDTH
//  in_rm        in   WIDTH  Rm operand
//  in_rs        in   8      Rs[7:0] shift amount
//  in_carry     in   1      current CPSR C flag
//  out_valid    out  1      result valid
//  out_ready    in   1      consumer accepts result
//  out_result   out  WIDTH  shifted operand 2
//  out_carry    out  1      shifter carry-out
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): all stage valids, out_valid, out_result and out_carry cleared to 0; in-flight ops discarded.
//  After reset, in_ready=1 in the following cycle.
//  Handshake:
//   - Transfer on in_valid&in_ready / out_valid&out_ready.
//   - Each stage loads when empty or its content moves on in the same cycle.
//   - in_ready = !s1_valid | s1_moves, purely combinational from out_ready; no bubble when streaming.
//   - out_* held stable while out_valid&!out_ready.
//  Latency PIPE_STAGES cycles; throughput 1/cycle.
//  Imm (in_imm=1): r = ROR(imm8, 2*rot); c = (rot==0) ? in_carry : r[WIDTH-1].
//  Imm shift (in_imm=0, in_regshift=0), n = in_shamt:
//   - LSL #0: rm, c=in_carry. LSL n: rm<<n, c=rm[WIDTH-n].
//   - LSR #0 = LSR #WIDTH: r=0, c=rm[WIDTH-1]. LSR n: c=rm[n-1].
//   - ASR #0 = ASR #WIDTH: r = all rm[WIDTH-1], c=rm[WIDTH-1]. ASR n: c=rm[n-1].
//   - ROR #0 = RRX: r={in_carry, rm[WIDTH-1:1]}, c=rm[0]. ROR n: c=rm[n-1].
//  Reg shift (in_regshift=1), a = in_rs[7:0]; a==0: r=rm, c=in_carry for all types.
//   - LSL: a<WIDTH as imm; a==WIDTH: r=0, c=rm[0]; a>WIDTH: r=0, c=0.
//   - LSR: a<WIDTH as imm; a==WIDTH: r=0, c=rm[WIDTH-1]; a>WIDTH: r=0, c=0.
//   - ASR: a>=WIDTH: r = all sign, c=rm[WIDTH-1].
//   - ROR: a mod WIDTH==0: r=rm, c=rm[WIDTH-1]; else rotate by a mod WIDTH, c=r[WIDTH-1].
//  in_rs bits above [7] never affect result. No X propagation from unused fields.
//  Simultaneous in and out transfer in a full pipe: both occur; occupancy unchanged.
// TESTING
//  1. in_imm=1, imm8=0xFF, rot=4, in_carry=0 -> 0xFF000000, carry 1, out_valid exactly PIPE_STAGES cycles after accept.
//  2. Reg LSL, rm=0x80000001, rs=32 -> 0, c=1; rs=33 -> 0, c=0; rs=0x100 -> rm unchanged, c=in_carry.
//  3. Imm ROR #0 (RRX), rm=0x00000003, in_carry=1 -> 0x80000001, c=1; imm ASR #0, rm=0x80000000 -> 0xFFFFFFFF, c=1.
//  4. Stream 8 back-to-back ops, out_ready low cycles 3-5 -> in_ready drops when pipe full, no loss/duplication, outputs stable while stalled, order preserved.
//  5. Drop reset_n for one cycle with 2 ops in flight -> out_valid=0, out_result=0 next cycle; next op starts a fresh latency count.
//  6. Random compare vs reference model, WIDTH=16 and 32, PIPE_STAGES=1 and 2, random out_ready.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// ARM-style operand-2 shifter with valid/ready handshake, WIDTH-generic, 1 or 2 stages.
// Decode folds every encoding into a kind+amount pair; the shift step then only applies it.
module pipelined_barrel_shifter #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2,
    localparam int SHW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_imm,
    input  logic             in_regshift,
    input  logic [1:0]       in_sh,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [3:0]       in_rot,
    input  logic [7:0]       in_imm8,
    input  logic [WIDTH-1:0] in_rm,
    input  logic [7:0]       in_rs,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry
);

    // PASS/ZERO/SIGN take their carry from cin; shifts derive it from val and amt.
    typedef enum logic [2:0] {K_PASS, K_ZERO, K_SIGN, K_LSL, K_LSR, K_ASR, K_ROR, K_RRX} kind_t;

    typedef struct packed {
        kind_t            kind;
        logic [SHW-1:0]   amt;
        logic [WIDTH-1:0] val;
        logic             cin;
    } dec_t;

    dec_t           dec;
    logic [SHW-1:0] rot_amt;
    logic           rs_ge;
    logic           rs_eq;
    logic [WIDTH:0] shifted;
    logic           feed_valid;
    logic           out_free;

    assign rot_amt  = SHW'({in_rot, 1'b0});
    assign rs_ge    = {1'b0, in_rs} >= 9'(WIDTH);
    assign rs_eq    = {1'b0, in_rs} == 9'(WIDTH);
    assign out_free = !out_valid || out_ready;

    always_comb begin
        dec.kind = K_PASS;
        dec.amt  = '0;
        dec.val  = in_rm;
        dec.cin  = in_carry;
        if (in_imm) begin
            dec.val = WIDTH'(in_imm8);
            if (in_rot != 4'd0) begin
                // a full-turn rotate leaves the byte low, so the MSB carry is 0
                if (rot_amt == '0) dec.cin = 1'b0;
                else begin
                    dec.kind = K_ROR;
                    dec.amt  = rot_amt;
                end
            end
        end else if (!in_regshift) begin
            dec.amt = in_shamt;
            case (in_sh)
                2'b00: if (in_shamt != '0) dec.kind = K_LSL;
                2'b01: if (in_shamt != '0) dec.kind = K_LSR;
                       else begin dec.kind = K_ZERO; dec.cin = in_rm[WIDTH-1]; end
                2'b10: if (in_shamt != '0) dec.kind = K_ASR;
                       else begin dec.kind = K_SIGN; dec.cin = in_rm[WIDTH-1]; end
                default: dec.kind = (in_shamt != '0) ? K_ROR : K_RRX;
            endcase
        end else if (in_rs != 8'd0) begin
            dec.amt = in_rs[SHW-1:0];
            case (in_sh)
                2'b00: if (!rs_ge) dec.kind = K_LSL;
                       else begin dec.kind = K_ZERO; dec.cin = rs_eq & in_rm[0]; end
                2'b01: if (!rs_ge) dec.kind = K_LSR;
                       else begin dec.kind = K_ZERO; dec.cin = rs_eq & in_rm[WIDTH-1]; end
                2'b10: if (!rs_ge) dec.kind = K_ASR;
                       else begin dec.kind = K_SIGN; dec.cin = in_rm[WIDTH-1]; end
                default: if (in_rs[SHW-1:0] != '0) dec.kind = K_ROR;
                         else dec.cin = in_rm[WIDTH-1];
            endcase
        end
    end

    function automatic logic [WIDTH:0] apply(input dec_t d);
        logic [WIDTH-1:0] r;
        logic             c;
        logic [SHW-1:0]   namt;
        logic [SHW-1:0]   lo;
        namt = '0 - d.amt;
        lo   = d.amt - SHW'(1);
        r    = d.val;
        c    = d.cin;
        case (d.kind)
            K_ZERO: r = '0;
            K_SIGN: r = {WIDTH{d.val[WIDTH-1]}};
            K_LSL:  begin r = d.val << d.amt; c = d.val[namt]; end
            K_LSR:  begin r = d.val >> d.amt; c = d.val[lo]; end
            K_ASR:  begin r = $signed(d.val) >>> d.amt; c = d.val[lo]; end
            K_ROR:  begin r = (d.val >> d.amt) | (d.val << namt); c = d.val[lo]; end
            K_RRX:  begin r = {d.cin, d.val[WIDTH-1:1]}; c = d.val[0]; end
            default: ;
        endcase
        return {c, r};
    endfunction

    generate
        if (PIPE_STAGES == 1) begin : g_one
            assign in_ready   = out_free;
            assign feed_valid = in_valid;
            assign shifted    = apply(dec);
        end else begin : g_two
            logic s1_valid;
            dec_t s1_dec;

            assign in_ready   = !s1_valid || out_free;
            assign feed_valid = s1_valid;
            assign shifted    = apply(s1_dec);

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    s1_valid <= 1'b0;
                    s1_dec   <= '0;
                end else if (in_ready) begin
                    s1_valid <= in_valid;
                    if (in_valid) s1_dec <= dec;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
        end else if (out_free) begin
            out_valid <= feed_valid;
            if (feed_valid) {out_carry, out_result} <= shifted;
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench: 32-bit/2-stage and 16-bit/1-stage shifters against an arithmetic reference model.
module tb_pipelined_barrel_shifter;
    localparam int AW = 32;
    localparam int AP = 2;
    localparam int BW = 16;
    localparam int BP = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        a_in_valid, a_in_ready, a_imm, a_regsh, a_cin, a_out_valid, a_out_ready, a_out_carry;
    logic [1:0]  a_sh;
    logic [4:0]  a_shamt;
    logic [3:0]  a_rot;
    logic [7:0]  a_imm8, a_rs;
    logic [31:0] a_rm, a_out_result;

    logic        b_in_valid, b_in_ready, b_imm, b_regsh, b_cin, b_out_valid, b_out_ready, b_out_carry;
    logic [1:0]  b_sh;
    logic [3:0]  b_shamt;
    logic [3:0]  b_rot;
    logic [7:0]  b_imm8, b_rs;
    logic [15:0] b_rm, b_out_result;

    pipelined_barrel_shifter #(.WIDTH(AW), .PIPE_STAGES(AP)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_imm(a_imm), .in_regshift(a_regsh), .in_sh(a_sh), .in_shamt(a_shamt),
        .in_rot(a_rot), .in_imm8(a_imm8), .in_rm(a_rm), .in_rs(a_rs), .in_carry(a_cin),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_result(a_out_result),
        .out_carry(a_out_carry)
    );

    pipelined_barrel_shifter #(.WIDTH(BW), .PIPE_STAGES(BP)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_imm(b_imm), .in_regshift(b_regsh), .in_sh(b_sh), .in_shamt(b_shamt),
        .in_rot(b_rot), .in_imm8(b_imm8), .in_rm(b_rm), .in_rs(b_rs), .in_carry(b_cin),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result),
        .out_carry(b_out_carry)
    );

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mask(int w);
        return (w == 64) ? '1 : (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] rotr(int w, logic [63:0] v, int k);
        if (k == 0) return v & mask(w);
        return ((v >> k) | (v << (w - k))) & mask(w);
    endfunction

    // Returns {carry, result} with the result in the low w bits.
    function automatic logic [64:0] ref_op(int w, logic imm, logic regsh, logic [1:0] sh, int shamt,
                                           int rot, logic [7:0] imm8, logic [63:0] rm_in, int rs,
                                           logic cin);
        logic [63:0] m, rm, r, se;
        logic        c, sign;
        int          n;
        m    = mask(w);
        rm   = rm_in & m;
        sign = rm[w-1];
        se   = sign ? (rm | ~m) : rm;
        if (imm) begin
            r = rotr(w, {56'd0, imm8}, (2 * rot) % w);
            c = (rot == 0) ? cin : r[w-1];
        end else begin
            n = regsh ? rs : shamt;
            if (regsh && n == 0) begin
                r = rm; c = cin;
            end else begin
                case (sh)
                    2'd0: if (n == 0) begin r = rm; c = cin; end
                          else begin
                              r = (n >= w) ? 64'd0 : (rm << n) & m;
                              c = (n <= w) ? rm[w-n] : 1'b0;
                          end
                    2'd1: begin
                        if (n == 0) n = w;
                        r = (n >= w) ? 64'd0 : rm >> n;
                        c = (n <= w) ? rm[n-1] : 1'b0;
                    end
                    2'd2: begin
                        if (n == 0) n = w;
                        r = (n >= w) ? (sign ? m : 64'd0) : (64'($signed(se) >>> n) & m);
                        c = (n >= w) ? sign : rm[n-1];
                    end
                    default: if (!regsh && n == 0) begin
                                 r = ({63'd0, cin} << (w - 1)) | (rm >> 1);
                                 c = rm[0];
                             end else begin
                                 r = rotr(w, rm, n % w);
                                 c = r[w-1];
                             end
                endcase
            end
        end
        return {c, r};
    endfunction

    function automatic logic [64:0] pk(int w, logic [64:0] cr);
        logic [64:0] v;
        v    = {1'b0, cr[63:0]};
        v[w] = cr[64];
        return v;
    endfunction

    // Scoreboard: expectations pushed at input transfer, popped at output transfer.
    logic [64:0] qa[$];
    logic [64:0] qb[$];
    logic        a_stall = 1'b0, b_stall = 1'b0;
    logic [64:0] a_hold, b_hold;
    int          a_seen = 0, b_seen = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            qa.delete(); qb.delete();
            a_stall = 1'b0; b_stall = 1'b0;
        end else begin
            if (a_stall) check("a_stall_hold", 65'({a_out_valid, a_out_carry, a_out_result}), a_hold);
            if (b_stall) check("b_stall_hold", 65'({b_out_valid, b_out_carry, b_out_result}), b_hold);
            if (a_out_valid && a_out_ready) begin
                a_seen++;
                if (qa.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL a_unexpected_out: got %h expected none", a_out_result);
                end else check("a_out", 65'({a_out_carry, a_out_result}), qa.pop_front());
            end
            if (b_out_valid && b_out_ready) begin
                b_seen++;
                if (qb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b_unexpected_out: got %h expected none", b_out_result);
                end else check("b_out", 65'({b_out_carry, b_out_result}), qb.pop_front());
            end
            a_stall = a_out_valid && !a_out_ready;
            b_stall = b_out_valid && !b_out_ready;
            a_hold  = 65'({a_out_valid, a_out_carry, a_out_result});
            b_hold  = 65'({b_out_valid, b_out_carry, b_out_result});
            if (a_in_valid && a_in_ready)
                qa.push_back(pk(AW, ref_op(AW, a_imm, a_regsh, a_sh, int'(a_shamt), int'(a_rot),
                                           a_imm8, 64'(a_rm), int'(a_rs), a_cin)));
            if (b_in_valid && b_in_ready)
                qb.push_back(pk(BW, ref_op(BW, b_imm, b_regsh, b_sh, int'(b_shamt), int'(b_rot),
                                           b_imm8, 64'(b_rm), int'(b_rs), b_cin)));
        end
    end

    // Single op on the 32-bit unit with an empty pipe; checks latency and the literal result.
    task automatic run_op(input string name, input logic imm, input logic regsh, input logic [1:0] sh,
                          input logic [4:0] shamt, input logic [3:0] rot, input logic [7:0] imm8,
                          input logic [31:0] rm, input logic [7:0] rs, input logic cin,
                          input logic [31:0] exp_r, input logic exp_c);
        int lat;
        a_imm = imm; a_regsh = regsh; a_sh = sh; a_shamt = shamt; a_rot = rot;
        a_imm8 = imm8; a_rm = rm; a_rs = rs; a_cin = cin; a_in_valid = 1'b1;
        #1;
        for (int i = 0; i < 20 && !a_in_ready; i++) begin @(posedge clk); #1; end
        check({name, "_accept"}, 65'(a_in_ready), 65'd1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        lat = 1;
        while (!a_out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        check({name, "_latency"}, 65'(lat), 65'(AP));
        check({name, "_result"}, 65'(a_out_result), 65'(exp_r));
        check({name, "_carry"}, 65'(a_out_carry), 65'(exp_c));
        @(posedge clk); #1;
    endtask

    function automatic logic [7:0] rnd_rs(int w);
        return ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 2 * w + 1)) : 8'($urandom);
    endfunction

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int sent, seen0;
        logic saw_block;
        a_in_valid = 0; a_out_ready = 1; a_imm = 0; a_regsh = 0; a_sh = 0; a_shamt = 0;
        a_rot = 0; a_imm8 = 0; a_rm = 0; a_rs = 0; a_cin = 0;
        b_in_valid = 0; b_out_ready = 1; b_imm = 0; b_regsh = 0; b_sh = 0; b_shamt = 0;
        b_rot = 0; b_imm8 = 0; b_rm = 0; b_rs = 0; b_cin = 0;

        // Pin the model with hand-computed cases
        check("model_imm_rot", pk(32, ref_op(32, 1, 0, 0, 0, 4, 8'hFF, 64'd0, 0, 0)), 65'({1'b1, 32'hFF000000}));
        check("model_rrx", pk(32, ref_op(32, 0, 0, 3, 0, 0, 0, 64'h3, 0, 1)), 65'({1'b1, 32'h80000001}));
        check("model_lsl33", pk(32, ref_op(32, 0, 1, 0, 0, 0, 0, 64'h80000001, 33, 1)), 65'd0);
        check("model_ror36", pk(32, ref_op(32, 0, 1, 3, 0, 0, 0, 64'h0000000F, 36, 0)), 65'({1'b1, 32'hF0000000}));
        check("model_w16_rot8", pk(16, ref_op(16, 1, 0, 0, 0, 8, 8'h80, 64'd0, 0, 1)), 65'({1'b0, 16'h0080}));
        check("model_w16_lsr16", pk(16, ref_op(16, 0, 1, 1, 0, 0, 0, 64'h8000, 16, 0)), 65'({1'b1, 16'h0000}));

        repeat (3) @(posedge clk);
        #1;
        check("reset_a_valid", 65'(a_out_valid), 65'd0);
        check("reset_a_result", 65'({a_out_carry, a_out_result}), 65'd0);
        check("reset_b_valid", 65'(b_out_valid), 65'd0);
        reset_n = 1'b1;
        #1;
        check("reset_in_ready", 65'({a_in_ready, b_in_ready}), 65'b11);
        @(posedge clk); #1;

        run_op("imm_rot4",   1, 0, 2'd0, 5'd0, 4'd4, 8'hFF, 32'h0, 8'd0, 0, 32'hFF000000, 1);
        run_op("reg_lsl32",  0, 1, 2'd0, 5'd0, 4'd0, 8'h0, 32'h80000001, 8'd32, 0, 32'h0, 1);
        run_op("reg_lsl33",  0, 1, 2'd0, 5'd0, 4'd0, 8'h0, 32'h80000001, 8'd33, 1, 32'h0, 0);
        // rs=0x100 reaches the 8-bit port as 0
        run_op("reg_lsl256", 0, 1, 2'd0, 5'd0, 4'd0, 8'h0, 32'h80000001, 8'h00, 1, 32'h80000001, 1);
        run_op("imm_rrx",    0, 0, 2'd3, 5'd0, 4'd0, 8'h0, 32'h00000003, 8'd0, 1, 32'h80000001, 1);
        run_op("imm_asr0",   0, 0, 2'd2, 5'd0, 4'd0, 8'h0, 32'h80000000, 8'd0, 0, 32'hFFFFFFFF, 1);
        run_op("imm_lsr0",   0, 0, 2'd1, 5'd0, 4'd0, 8'h0, 32'h80000000, 8'd0, 0, 32'h0, 1);
        run_op("reg_ror32",  0, 1, 2'd3, 5'd0, 4'd0, 8'h0, 32'h80000001, 8'd32, 0, 32'h80000001, 1);
        run_op("reg_asr200", 0, 1, 2'd2, 5'd0, 4'd0, 8'h0, 32'h40000000, 8'd200, 1, 32'h0, 0);
        run_op("imm_lsl4",   0, 0, 2'd0, 5'd4, 4'd0, 8'h0, 32'hF0000001, 8'd0, 0, 32'h00000010, 1);
        run_op("imm_rot0",   1, 1, 2'd2, 5'd7, 4'd0, 8'h5A, 32'hFFFFFFFF, 8'd9, 1, 32'h0000005A, 1);

        // Stream 8 ops with the consumer stalled in cycles 3-5
        sent = 0; seen0 = a_seen; saw_block = 1'b0;
        for (int cyc = 0; cyc < 60 && (sent < 8 || qa.size() != 0 || a_out_valid); cyc++) begin
            a_out_ready = !(cyc >= 3 && cyc <= 5);
            a_in_valid  = (sent < 8);
            a_imm = 0; a_regsh = sent[0]; a_sh = 2'(sent); a_shamt = 5'(3 * sent + 1);
            a_rs = 8'(5 * sent); a_rm = 32'h9E3779B9 * 32'(sent + 1); a_cin = sent[1];
            #1;
            if (a_in_valid && !a_in_ready) saw_block = 1'b1;
            if (a_in_valid && a_in_ready) sent++;
            @(posedge clk); #1;
        end
        a_in_valid = 0; a_out_ready = 1;
        check("stream_count", 65'(a_seen - seen0), 65'd8);
        check("stream_blocked", 65'(saw_block), 65'd1);

        // Reset with two ops in flight
        a_out_ready = 0;
        a_imm = 1; a_rot = 4'd4; a_imm8 = 8'hFF; a_cin = 0; a_in_valid = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a_in_valid = 0;
        check("flight_full", 65'({a_out_valid, a_in_ready}), 65'b10);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        check("flush_valid", 65'(a_out_valid), 65'd0);
        check("flush_result", 65'({a_out_carry, a_out_result}), 65'd0);
        check("flush_in_ready", 65'(a_in_ready), 65'd1);
        a_out_ready = 1;
        run_op("post_reset", 1, 0, 2'd0, 5'd0, 4'd4, 8'hFF, 32'h0, 8'd0, 0, 32'hFF000000, 1);

        // Random traffic on both units with random backpressure
        for (int cyc = 0; cyc < 3000; cyc++) begin
            a_in_valid = ($urandom_range(0, 3) != 0); a_out_ready = ($urandom_range(0, 3) != 0);
            a_imm = ($urandom_range(0, 3) == 0); a_regsh = 1'($urandom_range(0, 1));
            a_sh = 2'($urandom); a_shamt = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            a_rot = 4'($urandom); a_imm8 = 8'($urandom); a_rm = $urandom; a_rs = rnd_rs(AW);
            a_cin = 1'($urandom_range(0, 1));
            b_in_valid = ($urandom_range(0, 3) != 0); b_out_ready = ($urandom_range(0, 3) != 0);
            b_imm = ($urandom_range(0, 3) == 0); b_regsh = 1'($urandom_range(0, 1));
            b_sh = 2'($urandom); b_shamt = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            b_rot = 4'($urandom); b_imm8 = 8'($urandom); b_rm = 16'($urandom); b_rs = rnd_rs(BW);
            b_cin = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        a_in_valid = 0; b_in_valid = 0; a_out_ready = 1; b_out_ready = 1;
        repeat (10) @(posedge clk);
        #1;
        check("drain", 65'({qa.size() == 0, qb.size() == 0, a_out_valid, b_out_valid}), 65'b1100);
        check("random_seen", 65'({a_seen > 1000, b_seen > 1000}), 65'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
